// File: rtl/pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_rr_arbiter
// Packet-level round-robin arbiter. Four requesters each write words into a
// private fall-through FIFO; the arbiter grants one queue at a time and
// forwards a whole packet (header words, data words, one EOP word) before it
// re-arbitrates. Round-robin search starts at the queue after the last one
// that completed a packet.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_data_N, in_ctrl_N  : word and ctrl from requester N (N = 0..3)
//   in_wr_N               : write strobe for requester N
//   in_rdy_N              : requester N may write next cycle (FIFO not nearly full)
//   out_data, out_ctrl    : registered word forwarded to the next stage
//   out_wr                : registered write strobe to the next stage
//   out_rdy               : next stage accepts a word this cycle
//   cur_grant             : index of the currently granted queue
//   pkt_done              : one-cycle pulse together with the EOP word's out_wr
// -----------------------------------------------------------------------------
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
    input  logic                  in_wr_0,
    output logic                  in_rdy_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_1,
    input  logic                  in_wr_1,
    output logic                  in_rdy_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_2,
    input  logic                  in_wr_2,
    output logic                  in_rdy_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_3,
    input  logic                  in_wr_3,
    output logic                  in_rdy_3,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [1:0]            cur_grant,
    output logic                  pkt_done
);

    localparam int L_WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int L_DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] L_CNT_FULL = (FIFO_DEPTH_BITS + 1)'(L_DEPTH);
    // Nearly full leaves one slot so a requester that sees in_rdy high can
    // still write on the following cycle.
    localparam logic [FIFO_DEPTH_BITS:0] L_CNT_NEAR = (FIFO_DEPTH_BITS + 1)'(L_DEPTH - 1);
    localparam logic [FIFO_DEPTH_BITS:0] L_CNT_ZERO = {(FIFO_DEPTH_BITS + 1){1'b0}};
    localparam logic [FIFO_DEPTH_BITS:0] L_CNT_ONE  = (FIFO_DEPTH_BITS + 1)'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0] L_PTR_ONE = FIFO_DEPTH_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND_HDR  = 2'd1,
        S_SEND_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_grant;
    logic [1:0]            r_last_grant;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;
    logic                  r_pkt_done;

    logic [L_WORD_W-1:0]   w_wdata [4];
    logic [L_WORD_W-1:0]   w_head  [4];
    logic [3:0]            w_wr;
    logic [3:0]            w_empty;
    logic [3:0]            w_nearly_full;
    logic [3:0]            w_pop_q;
    logic                  w_pop;
    logic [L_WORD_W-1:0]   w_head_sel;
    logic [CTRL_WIDTH-1:0] w_head_ctrl;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [1:0]            w_next_grant;
    logic [1:0]            w_idx;
    logic                  w_found;

    assign w_wdata[0] = {in_ctrl_0, in_data_0};
    assign w_wdata[1] = {in_ctrl_1, in_data_1};
    assign w_wdata[2] = {in_ctrl_2, in_data_2};
    assign w_wdata[3] = {in_ctrl_3, in_data_3};
    assign w_wr       = {in_wr_3, in_wr_2, in_wr_1, in_wr_0};

    assign in_rdy_0 = !w_nearly_full[0];
    assign in_rdy_1 = !w_nearly_full[1];
    assign in_rdy_2 = !w_nearly_full[2];
    assign in_rdy_3 = !w_nearly_full[3];

    // Only the granted queue is ever popped, and only while a packet is open.
    assign w_pop       = (r_state != S_IDLE) && out_rdy && !w_empty[r_grant];
    assign w_head_sel  = w_head[r_grant];
    assign w_head_ctrl = w_head_sel[L_WORD_W-1 -: CTRL_WIDTH];
    assign w_head_data = w_head_sel[DATA_WIDTH-1:0];

    // Per-requester fall-through FIFO: the head word is visible whenever the
    // queue is non-empty, so a pop and its forwarded word share one cycle.
    for (genvar g = 0; g < 4; g++) begin : g_fifo
        logic [L_WORD_W-1:0]        r_mem [L_DEPTH];
        logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
        logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
        logic [FIFO_DEPTH_BITS:0]   r_count;
        logic                       w_push;

        assign w_pop_q[g]       = w_pop && (r_grant == 2'(g));
        // A write into a full queue is only kept if a pop frees a slot.
        assign w_push           = w_wr[g] && ((r_count != L_CNT_FULL) || w_pop_q[g]);
        assign w_empty[g]       = (r_count == L_CNT_ZERO);
        assign w_nearly_full[g] = (r_count >= L_CNT_NEAR);
        assign w_head[g]        = r_mem[r_rd_ptr];

        // Storage write port.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wdata[g];
            end
        end

        // Pointers and occupancy; reset flushes the queue.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_ptr <= {FIFO_DEPTH_BITS{1'b0}};
                r_wr_ptr <= {FIFO_DEPTH_BITS{1'b0}};
                r_count  <= L_CNT_ZERO;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
                end
                if (w_pop_q[g]) begin
                    r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
                end
                case ({w_push, w_pop_q[g]})
                    2'b10:   r_count <= r_count + L_CNT_ONE;
                    2'b01:   r_count <= r_count - L_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Round-robin search: last_grant+1 first, last_grant itself last.
    always_comb begin
        w_next_grant = r_grant;
        w_found      = 1'b0;
        w_idx        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && !w_empty[w_idx]) begin
                w_found      = 1'b1;
                w_next_grant = w_idx;
            end else begin
                w_found      = w_found;
            end
        end
    end

    // Packet FSM with registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd3;
            r_grant      <= 2'd0;
            r_out_wr     <= 1'b0;
            r_out_data   <= {DATA_WIDTH{1'b0}};
            r_out_ctrl   <= {CTRL_WIDTH{1'b0}};
            r_pkt_done   <= 1'b0;
        end else begin
            r_out_wr   <= w_pop;
            r_pkt_done <= 1'b0;
            if (w_pop) begin
                r_out_data <= w_head_data;
                r_out_ctrl <= w_head_ctrl;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next_grant;
                        r_state <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    // First zero-ctrl word ends the header section.
                    if (w_pop && (w_head_ctrl == {CTRL_WIDTH{1'b0}})) begin
                        r_state <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    // Non-zero ctrl after data words marks end of packet.
                    if (w_pop && (w_head_ctrl != {CTRL_WIDTH{1'b0}})) begin
                        r_last_grant <= r_grant;
                        r_pkt_done   <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign out_wr    = r_out_wr;
    assign pkt_done  = r_pkt_done;
    assign cur_grant = r_grant;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pkt_rr_arbiter
// Self-checking bench. A packet-level reference model keeps one word queue per
// requester; it picks the next queue by the round-robin rule, expects the
// first word two cycles after the choice, then one word per cycle whenever the
// next stage was ready and the granted queue held a word.
// -----------------------------------------------------------------------------
module tb_pkt_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [63:0] t_data [4];
    logic [7:0]  t_ctrl [4];
    logic [3:0]  t_wr;
    logic [3:0]  rdy_v;
    logic        t_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic [1:0]  cur_grant;
    logic        pkt_done;

    pkt_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .in_data_0 (t_data[0]), .in_ctrl_0 (t_ctrl[0]), .in_wr_0 (t_wr[0]), .in_rdy_0 (rdy_v[0]),
        .in_data_1 (t_data[1]), .in_ctrl_1 (t_ctrl[1]), .in_wr_1 (t_wr[1]), .in_rdy_1 (rdy_v[1]),
        .in_data_2 (t_data[2]), .in_ctrl_2 (t_ctrl[2]), .in_wr_2 (t_wr[2]), .in_rdy_2 (rdy_v[2]),
        .in_data_3 (t_data[3]), .in_ctrl_3 (t_ctrl[3]), .in_wr_3 (t_wr[3]), .in_rdy_3 (rdy_v[3]),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (t_rdy),
        .cur_grant (cur_grant),
        .pkt_done  (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Words still to be written by each requester, and words inside the DUT.
    logic [71:0] src [4][$];
    logic [71:0] mq  [4][$];

    int cyc        = 0;
    int m_dec_cyc  = 0;
    bit m_active   = 1'b0;
    bit m_indata   = 1'b0;
    int m_cur      = 0;
    int m_last     = 3;
    int avail_prev = 0;
    bit rdy_prev   = 1'b0;

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_pkt(input int q, input int nh, input int nd);
        logic [7:0] c;
        for (int i = 0; i < nh; i++) begin
            c = 8'($urandom_range(255, 1));
            src[q].push_back({c, $urandom, $urandom});
        end
        for (int i = 0; i < nd; i++) begin
            src[q].push_back({8'h00, $urandom, $urandom});
        end
        c = 8'($urandom_range(255, 1));
        src[q].push_back({c, $urandom, $urandom});
    endtask

    // Called just after each falling edge: compare the DUT against the model.
    task automatic monitor();
        bit          exp_wr;
        bit          exp_done;
        bit          found;
        logic [71:0] w;
        int          idx;
        cyc++;
        exp_wr   = m_active && ((cyc - m_dec_cyc) >= 2) && rdy_prev && (avail_prev > 0);
        exp_done = 1'b0;
        check_val("out_wr", out_wr, exp_wr);
        if (out_wr && exp_wr) begin
            w = mq[m_cur].pop_front();
            check_val("out_data", out_data, w[63:0]);
            check_val("out_ctrl", out_ctrl, w[71:64]);
            check_val("cur_grant", cur_grant, m_cur);
            if (w[71:64] == 8'h00) begin
                m_indata = 1'b1;
            end else if (m_indata) begin
                exp_done = 1'b1;
                m_last   = m_cur;
                m_active = 1'b0;
            end
        end
        check_val("pkt_done", pkt_done, exp_done);
        if (!m_active) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (!found && (mq[idx].size() > 0)) begin
                    found     = 1'b1;
                    m_active  = 1'b1;
                    m_cur     = idx;
                    m_dec_cyc = cyc;
                    m_indata  = 1'b0;
                end
            end
        end
        for (int q = 0; q < 4; q++) begin
            check_val($sformatf("in_rdy_%0d", q), rdy_v[q], (mq[q].size() < 7));
        end
        avail_prev = m_active ? mq[m_cur].size() : 0;
    endtask

    // Drive one cycle of stimulus, then check after the next falling edge.
    task automatic run_cycles(input int n, input int p_wr, input int p_rdy);
        logic [71:0] w;
        for (int i = 0; i < n; i++) begin
            t_rdy    = ($urandom_range(99) < p_rdy);
            rdy_prev = t_rdy;
            for (int q = 0; q < 4; q++) begin
                if ((src[q].size() > 0) && rdy_v[q] && ($urandom_range(99) < p_wr)) begin
                    w         = src[q].pop_front();
                    t_wr[q]   = 1'b1;
                    t_ctrl[q] = w[71:64];
                    t_data[q] = w[63:0];
                    mq[q].push_back(w);
                end else begin
                    t_wr[q]   = 1'b0;
                    t_ctrl[q] = 8'($urandom);
                    t_data[q] = {$urandom, $urandom};
                end
            end
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        t_wr  = 4'h0;
        repeat (n) @(negedge clk);
        check_val("rst_out_wr", out_wr, 1'b0);
        check_val("rst_out_data", out_data, 64'h0);
        check_val("rst_out_ctrl", out_ctrl, 8'h00);
        check_val("rst_pkt_done", pkt_done, 1'b0);
        check_val("rst_cur_grant", cur_grant, 2'd0);
        check_val("rst_in_rdy", rdy_v, 4'hF);
        reset = 1'b0;
        for (int q = 0; q < 4; q++) begin
            mq[q].delete();
            src[q].delete();
        end
        m_active   = 1'b0;
        m_indata   = 1'b0;
        m_last     = 3;
        avail_prev = 0;
    endtask

    initial begin
        int guard;
        bit pending;
        reset = 1'b1;
        t_rdy = 1'b0;
        t_wr  = 4'h0;
        for (int q = 0; q < 4; q++) begin
            t_data[q] = 64'h0;
            t_ctrl[q] = 8'h00;
        end
        do_reset(3);

        // Single packet on queue 2.
        src[2].push_back({8'hFF, 64'h0000_0000_0000_2001});
        src[2].push_back({8'h00, 64'hDEAD_BEEF_0000_0001});
        src[2].push_back({8'h00, 64'hDEAD_BEEF_0000_0002});
        src[2].push_back({8'h00, 64'hDEAD_BEEF_0000_0003});
        src[2].push_back({8'h08, 64'h0000_0000_0000_E0F2});
        run_cycles(12, 100, 100);

        // All four queues preloaded, then drained in order 0,1,2,3.
        do_reset(1);
        for (int q = 0; q < 4; q++) gen_pkt(q, 1, 2);
        run_cycles(6, 100, 0);
        run_cycles(30, 100, 100);

        // Queue 1 back-to-back packets, queue 3 one packet.
        do_reset(1);
        gen_pkt(1, 1, 2);
        gen_pkt(1, 2, 1);
        gen_pkt(3, 1, 3);
        run_cycles(30, 100, 100);

        // out_rdy toggling on a 6-word packet.
        do_reset(1);
        gen_pkt(1, 1, 4);
        for (int i = 0; i < 20; i++) run_cycles(1, 100, (i % 2 == 0) ? 0 : 100);

        // Fill queue 0 with the next stage blocked, then reset mid-packet.
        do_reset(1);
        gen_pkt(0, 1, 6);
        run_cycles(10, 100, 0);
        check_val("fill_in_rdy_0", rdy_v[0], 1'b0);
        check_val("fill_accepted", mq[0].size(), 7);
        run_cycles(3, 100, 100);
        do_reset(1);
        run_cycles(10, 0, 100);

        // Randomised traffic with starvation and back-pressure.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            for (int q = 0; q < 4; q++) begin
                if ((src[q].size() < 16) && ($urandom_range(15) == 0)) begin
                    gen_pkt(q, $urandom_range(2, 1), $urandom_range(4, 1));
                end
            end
            run_cycles(1, 60, 70);
        end

        // Drain everything with the next stage always ready.
        guard   = 0;
        pending = 1'b1;
        while (pending && (guard < 2000)) begin
            run_cycles(1, 100, 100);
            guard++;
            pending = m_active;
            for (int q = 0; q < 4; q++) begin
                if ((src[q].size() > 0) || (mq[q].size() > 0)) pending = 1'b1;
            end
        end
        check_val("drain_complete", pending, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width of each data bus.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, width of each ctrl bus.
REQ-003 SHALL have parameter FIFO_DEPTH_BITS, default 3, log2 of per-queue input FIFO depth.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_data_N  input  DATA_WIDTH  word from requester N (N=0..3).
REQ-007 SHALL have ports in_ctrl_N  input  CTRL_WIDTH  ctrl byte for requester N.
REQ-008 SHALL have ports in_wr_N  input  1  write strobe for requester N.
REQ-009 SHALL have ports in_rdy_N  output  1  requester N may write next cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered word to next stage.
REQ-011 SHALL have port out_ctrl  output  CTRL_WIDTH  registered ctrl to next stage.
REQ-012 SHALL have port out_wr  output  1  registered write strobe to next stage.
REQ-013 SHALL have port out_rdy  input  1  next stage accepts a word this cycle.
REQ-014 SHALL have port cur_grant  output  2  index of queue currently granted.
REQ-015 SHALL have port pkt_done  output  1  one-cycle pulse when a packet's last word is written out.

Function
REQ-016 SHALL buffer each requester in its own fallthrough_small_fifo of width CTRL_WIDTH+DATA_WIDTH and depth 2^FIFO_DEPTH_BITS; writes on in_wr_N, unconditionally.
REQ-017 SHALL drive in_rdy_N = !nearly_full of FIFO N, combinationally.
REQ-018 SHALL treat a packet as: one or more module-header words (ctrl != 0), then one or more data words (ctrl == 0), then exactly one end-of-packet word (ctrl != 0).
REQ-019 SHALL implement states IDLE, SEND_HDR, SEND_DATA.
REQ-020 IDLE: if any FIFO non-empty, SHALL select the first non-empty queue searching from last_grant+1 upward modulo 4, load grant, go to SEND_HDR; no word is forwarded in IDLE.
REQ-021 SEND_HDR: when out_rdy and granted FIFO non-empty, SHALL pop one word and forward it; if popped ctrl == 0, go to SEND_DATA.
REQ-022 SEND_DATA: when out_rdy and granted FIFO non-empty, SHALL pop and forward one word; if popped ctrl != 0 (EOP), set last_grant <= grant, pulse pkt_done with that write, go to IDLE.
REQ-023 Forwarded word SHALL appear on out_data/out_ctrl with out_wr=1 exactly one cycle after the pop; out_wr SHALL be 0 in all other cycles.
REQ-024 Granted FIFO empty mid-packet SHALL stall (no pop, out_wr=0) while holding grant and state; no other queue may be served until EOP.
REQ-025 out_rdy low SHALL stall identically; no word is dropped or duplicated.
REQ-026 Non-granted FIFOs SHALL never be popped; simultaneous writes to all four FIFOs and a pop SHALL all be honoured in the same cycle.
REQ-027 Minimum gap between EOP of one packet and first word of the next SHALL be one IDLE cycle; arbitration latency from IDLE with non-empty FIFO to first out_wr is 2 cycles.
REQ-028 cur_grant SHALL reflect the registered grant; it is valid in SEND_HDR/SEND_DATA and holds its last value in IDLE.
REQ-029 last_grant SHALL wrap 3 -> 0.

Reset
REQ-030 On reset SHALL set state=IDLE, last_grant=3, grant=0, out_wr=0, out_data=0, out_ctrl=0, pkt_done=0, and flush all four FIFOs.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no further out_wr; first packet after reset is served from queue 0 if it is non-empty.

Verification
REQ-032 Single packet on queue 2 (hdr ctrl 0xFF, 3 data words, EOP ctrl 0x08), out_rdy=1 -> 5 consecutive out_wr words, in order, first 2 cycles after first write visible, pkt_done on 5th, cur_grant=2.
REQ-033 All four queues preloaded with one 4-word packet each after reset -> output order 0,1,2,3, one IDLE cycle between packets, no interleaving.
REQ-034 Queue 1 back-to-back packets, queue 3 one packet -> order 1,3,1 (round-robin fairness).
REQ-035 out_rdy toggled 0/1 every cycle during a 6-word packet -> exactly 6 out_wr pulses, data intact; queue 1 starved mid-packet for 3 cycles -> out_wr=0 those cycles, grant held.
REQ-036 Write 7 words into queue 0 with out_rdy=0 -> in_rdy_0 deasserts at nearly_full; reset mid-packet -> all outputs zero next cycle, in_rdy_N=1, no residual words emitted.
